// File: rtl/muldiv_pkg.sv
// Shared encodings for the EX-stage multiply/divide unit: op codes, FSM states
// and the decode used by the ID-stage controller.
package muldiv_pkg;

    localparam logic [3:0] OP_NONE  = 4'd0;
    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;

    typedef enum logic [1:0] {
        StIdle,
        StCalc,
        StDone
    } state_e;

    // Maps the R-type funct field to a muldiv op; non-muldiv functs give OP_NONE.
    function automatic logic [3:0] decode_funct(input logic [5:0] funct);
        case (funct)
            6'h10:   return OP_MFHI;
            6'h11:   return OP_MTHI;
            6'h12:   return OP_MFLO;
            6'h13:   return OP_MTLO;
            6'h18:   return OP_MULT;
            6'h19:   return OP_MULTU;
            6'h1A:   return OP_DIV;
            6'h1B:   return OP_DIVU;
            default: return OP_NONE;
        endcase
    endfunction

endpackage

// File: rtl/ex_muldiv_if.sv
// Request/response bundle between the ID/EX register, hazard logic and the muldiv unit.
interface ex_muldiv_if #(
    parameter int unsigned WIDTH = 32
);
    logic             req;
    logic [3:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             flush;
    logic             busy;
    logic             stall;
    logic [WIDTH-1:0] rdata;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output req, op, a, b, flush,
        input  busy, stall, rdata, hi, lo
    );

    modport slave (
        input  req, op, a, b, flush,
        output busy, stall, rdata, hi, lo
    );
endinterface

// File: rtl/muldiv_iter.sv
// Unsigned iterative datapath: shift-add multiply or restoring divide, one bit per step.
module muldiv_iter #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               step,
    input  logic               is_div,
    input  logic [WIDTH-1:0]   opa,
    input  logic [WIDTH-1:0]   opb,
    output logic               done,
    output logic [2*WIDTH-1:0] prod,
    output logic [WIDTH-1:0]   quo,
    output logic [WIDTH-1:0]   rem
);
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH:0]     rem_q, rem_d;
    logic [WIDTH-1:0]   opd_q;
    logic               div_q;
    logic [CNT_W-1:0]   cnt_q;

    logic [WIDTH-1:0]   mcand;
    logic [WIDTH:0]     sum;
    logic               ge;
    logic [WIDTH-1:0]   diff;

    // rem_q holds the partial remainder with the next dividend bit already shifted in.
    always_comb begin
        mcand = acc_q[0] ? opd_q : '0;
        sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, mcand};
        ge    = rem_q >= {1'b0, opd_q};
        diff  = rem_q[WIDTH-1:0] - opd_q;
        acc_d = acc_q;
        rem_d = rem_q;
        if (start) begin
            if (is_div) begin
                acc_d = {{WIDTH{1'b0}}, opa[WIDTH-2:0], 1'b0};
                rem_d = {{WIDTH{1'b0}}, opa[WIDTH-1]};
            end else begin
                acc_d = {{WIDTH{1'b0}}, opb};
                rem_d = '0;
            end
        end else if (step) begin
            if (div_q) begin
                acc_d = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-2:0], ge};
                rem_d = {(ge ? diff : rem_q[WIDTH-1:0]), acc_q[WIDTH-1]};
            end else begin
                acc_d = {sum, acc_q[WIDTH-1:1]};
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_q <= '0;
            rem_q <= '0;
            opd_q <= '0;
            div_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            acc_q <= acc_d;
            rem_q <= rem_d;
            if (start) begin
                opd_q <= is_div ? opb : opa;
                div_q <= is_div;
                cnt_q <= '0;
            end else if (step) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign done = step && (cnt_q == CNT_W'(WIDTH - 1));
    assign prod = acc_q;
    assign quo  = acc_q[WIDTH-1:0];
    assign rem  = rem_q[WIDTH:1];

endmodule

// File: rtl/ex_muldiv.sv
// EX-stage multiply/divide unit: control FSM, sign handling, HI/LO registers and stall.
module ex_muldiv
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 5
) (
    input  logic         clk,
    input  logic         rst,
    ex_muldiv_if.slave   bus
);
    state_e             state_q, state_d;
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic               neg_a_q, neg_b_q, bzero_q, div_q;

    logic               is_arith, is_div, is_signed, accept, start, done;
    logic [WIDTH-1:0]   mag_a, mag_b, quo, rem;
    logic [2*WIDTH-1:0] prod, prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

    assign is_arith  = bus.op inside {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU};
    assign is_div    = bus.op inside {OP_DIV, OP_DIVU};
    assign is_signed = bus.op inside {OP_MULT, OP_DIV};
    assign accept    = bus.req && !bus.flush && (state_q == StIdle);
    assign start     = accept && is_arith;
    assign mag_a     = (is_signed && bus.a[WIDTH-1]) ? -bus.a : bus.a;
    assign mag_b     = (is_signed && bus.b[WIDTH-1]) ? -bus.b : bus.b;

    muldiv_iter #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_iter (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .step   (state_q == StCalc),
        .is_div (is_div),
        .opa    (mag_a),
        .opb    (mag_b),
        .done   (done),
        .prod   (prod),
        .quo    (quo),
        .rem    (rem)
    );

    // Neg flags are only ever set for signed ops, so unsigned results pass through.
    assign prod_fix = (neg_a_q ^ neg_b_q) ? -prod : prod;
    assign quo_fix  = (neg_a_q ^ neg_b_q) ? -quo : quo;
    assign rem_fix  = neg_a_q ? -rem : rem;

    always_comb begin
        state_d = state_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            StIdle: begin
                if (accept) begin
                    if (is_arith)              state_d = StCalc;
                    if (bus.op == OP_MTHI)     hi_d    = bus.a;
                    if (bus.op == OP_MTLO)     lo_d    = bus.a;
                end
            end
            StCalc: begin
                if (bus.flush)                 state_d = StIdle;
                else if (done)                 state_d = StDone;
            end
            StDone: begin
                state_d = StIdle;
                if (!bus.flush) begin
                    if (div_q) begin
                        // Divide by zero: remainder path already yields raw a.
                        hi_d = rem_fix;
                        lo_d = bzero_q ? '1 : quo_fix;
                    end else begin
                        {hi_d, lo_d} = prod_fix;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            hi_q    <= '0;
            lo_q    <= '0;
            neg_a_q <= 1'b0;
            neg_b_q <= 1'b0;
            bzero_q <= 1'b0;
            div_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            if (start) begin
                neg_a_q <= is_signed && bus.a[WIDTH-1];
                neg_b_q <= is_signed && bus.b[WIDTH-1];
                bzero_q <= (bus.b == '0);
                div_q   <= is_div;
            end
        end
    end

    assign bus.busy  = (state_q != StIdle);
    assign bus.stall = bus.req && (bus.op != OP_NONE) && bus.busy;
    assign bus.rdata = (bus.op == OP_MFHI) ? hi_q :
                       (bus.op == OP_MFLO) ? lo_q : '0;
    assign bus.hi    = hi_q;
    assign bus.lo    = lo_q;

endmodule
